nv_nvdla_qchannel_ctrl: RTL and testbench

- Parametrised Q-channel low-power controller that wraps any NVDLA sub-unit behind a CSB-style request gate.
- Replaces hard-wired per-unit controllers. Adds:
  - configurable request-channel count
  - configurable drain length
  - qdeny support, via a busy timeout and via drain abort
  - a registered qactive wake hint
- Sits between the power controller's Q-channel and the sub-unit's request/done inputs. The sub-unit's op-enable feeds back as busy_i.

---
 rtl/nv_nvdla_qchannel_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_nv_nvdla_qchannel_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_qchannel_ctrl.sv
// nv_nvdla_qchannel_ctrl
// Q-channel low-power controller placed in front of an NVDLA sub-unit.
// While the unit is running it passes request valids and done pulses through.
// When the power controller asks for quiescence (qreqn low), the controller
// drains an idle unit for a fixed number of cycles and then accepts. It denies
// the request if the unit stays busy past a timeout, or if new work arrives
// during the drain.
module nv_nvdla_qchannel_ctrl #(
  parameter int NUM_REQ      = 1,
  parameter int DRAIN_CYCLES = 8,
  parameter int DENY_TIMEOUT = 16
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               qreqn,
  output logic               qacceptn,
  output logic               qdeny,
  output logic               qactive,
  input  logic               busy_i,
  input  logic [NUM_REQ-1:0] req_vld_i,
  output logic [NUM_REQ-1:0] req_vld_o,
  input  logic               done_i,
  output logic               done_o,
  output logic [1:0]         state_o
);

  // One counter is shared by the drain phase and the deny timeout, so it is
  // sized for the larger of the two.
  localparam int CNT_MAX = (DRAIN_CYCLES > DENY_TIMEOUT) ? DRAIN_CYCLES : DENY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DENY_LAST  = CNT_W'((DENY_TIMEOUT > 0) ? (DENY_TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DENY  = 2'b11
  } qch_state_e;

  // A controller with no request channels or an empty drain is meaningless.
  if (NUM_REQ < 1 || DRAIN_CYCLES < 1) begin : g_param_err
    $error("nv_nvdla_qchannel_ctrl: NUM_REQ and DRAIN_CYCLES must both be >= 1");
  end

  qch_state_e       state_r;
  qch_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             qactive_r;
  logic             any_req_s;
  logic             idle_s;
  logic             qacceptn_s;
  logic             qdeny_s;
  logic             req_gate_s;
  logic             done_gate_s;

  assign any_req_s = |req_vld_i;
  assign idle_s    = !busy_i && !any_req_s;

  // State and counter registers; reset lands in STOP with the counter cleared.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_r <= ST_STOP;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Wake hint: one-cycle-late view of pending work, independent of state.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      qactive_r <= 1'b0;
    end else begin
      qactive_r <= any_req_s || busy_i;
    end
  end

  // Next-state and next-counter selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_STOP: begin
        cnt_nxt_s = CNT_ZERO;
        if (qreqn) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_RUN: begin
        if (qreqn) begin
          cnt_nxt_s = CNT_ZERO;
        end else if (idle_s) begin
          // An idle unit drains even if the timeout would also fire now.
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = CNT_ZERO;
        end else if (DENY_TIMEOUT != 0) begin
          if (cnt_r == DENY_LAST) begin
            state_nxt_s = ST_DENY;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          // Timeout disabled: wait for the unit to go idle indefinitely.
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DRAIN: begin
        if (!idle_s) begin
          // New work during the drain aborts it, even on the final cycle.
          state_nxt_s = ST_DENY;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_STOP;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DENY: begin
        cnt_nxt_s = CNT_ZERO;
        // Stay denied until the power controller withdraws its request.
        if (qreqn) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DENY;
        end
      end
      default: begin
        state_nxt_s = ST_STOP;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Q-channel handshake and gating enables, decoded purely from the state register.
  always_comb begin
    qacceptn_s  = 1'b0;
    qdeny_s     = 1'b0;
    req_gate_s  = 1'b0;
    done_gate_s = 1'b0;
    case (state_r)
      ST_STOP: begin
        qacceptn_s = 1'b0;
      end
      ST_RUN: begin
        qacceptn_s  = 1'b1;
        req_gate_s  = 1'b1;
        done_gate_s = 1'b1;
      end
      ST_DRAIN: begin
        // Outstanding completions may still land while draining.
        qacceptn_s  = 1'b1;
        done_gate_s = 1'b1;
      end
      ST_DENY: begin
        qacceptn_s  = 1'b1;
        qdeny_s     = 1'b1;
        req_gate_s  = 1'b1;
        done_gate_s = 1'b1;
      end
      default: begin
        qacceptn_s  = 1'b0;
        qdeny_s     = 1'b0;
        req_gate_s  = 1'b0;
        done_gate_s = 1'b0;
      end
    endcase
  end

  assign qacceptn  = qacceptn_s;
  assign qdeny     = qdeny_s;
  assign qactive   = qactive_r;
  assign req_vld_o = req_vld_i & {NUM_REQ{req_gate_s}};
  assign done_o    = done_i & done_gate_s;
  assign state_o   = state_r;

endmodule

// File: tb/tb_nv_nvdla_qchannel_ctrl.sv
// Testbench for nv_nvdla_qchannel_ctrl: a per-cycle vector table followed by
// hand-written sequences for the timeout, drain abort, reset-in-drain and
// timeout-disabled cases.
module tb_nv_nvdla_qchannel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  // Main instance: NUM_REQ=3, DRAIN_CYCLES=8, DENY_TIMEOUT=16.
  logic       qreqn, busy, done_in;
  logic [2:0] req_in;
  logic       qacceptn, qdeny, qactive, done_out;
  logic [2:0] req_out;
  logic [1:0] state;
  // Second instance: NUM_REQ=1, DRAIN_CYCLES=8, timeout deny disabled.
  logic       qreqn2, busy2, done_in2;
  logic [0:0] req_in2;
  logic       qacceptn2, qdeny2, qactive2, done_out2;
  logic [0:0] req_out2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_qchannel_ctrl #(.NUM_REQ(3), .DRAIN_CYCLES(8), .DENY_TIMEOUT(16)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .qreqn(qreqn), .qacceptn(qacceptn),
    .qdeny(qdeny), .qactive(qactive), .busy_i(busy), .req_vld_i(req_in),
    .req_vld_o(req_out), .done_i(done_in), .done_o(done_out), .state_o(state)
  );

  nv_nvdla_qchannel_ctrl #(.NUM_REQ(1), .DRAIN_CYCLES(8), .DENY_TIMEOUT(0)) dut_nt (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .qreqn(qreqn2), .qacceptn(qacceptn2),
    .qdeny(qdeny2), .qactive(qactive2), .busy_i(busy2), .req_vld_i(req_in2),
    .req_vld_o(req_out2), .done_i(done_in2), .done_o(done_out2), .state_o(state2)
  );

  typedef struct {
    logic       rst;
    logic       qreqn;
    logic       busy;
    logic [2:0] req;
    logic       done;
    logic [1:0] e_state;
    logic       e_qacceptn;
    logic       e_qdeny;
    logic [2:0] e_req;
    logic       e_done;
    logic       e_qactive;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock edge, then settle past it before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic q, input logic b, input logic [2:0] rq,
                     input logic d, input logic [1:0] es, input logic ea, input logic ed,
                     input logic [2:0] er, input logic edn, input logic eact);
    vec_t v;
    v.rst = r; v.qreqn = q; v.busy = b; v.req = rq; v.done = d;
    v.e_state = es; v.e_qacceptn = ea; v.e_qdeny = ed; v.e_req = er;
    v.e_done = edn; v.e_qactive = eact;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; qreqn = 1'b0; busy = 1'b0; req_in = 3'b000; done_in = 1'b0;
    qreqn2 = 1'b0; busy2 = 1'b0; req_in2 = 1'b0; done_in2 = 1'b0;

    // rst qreqn busy req done | state qacceptn qdeny req_o done_o qactive
    add(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'b101, 1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 2'd1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b101, 1'b1, 2'd1, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    // Idle drain: eight DRAIN cycles, then STOP.
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    // STOP blocks requests and done, but qactive still reports pending work.
    add(1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; qreqn = vecs[i].qreqn; busy = vecs[i].busy;
      req_in = vecs[i].req; done_in = vecs[i].done;
      step();
      chk($sformatf("vec%0d state", i), {6'd0, state}, {6'd0, vecs[i].e_state});
      chk($sformatf("vec%0d qacceptn", i), {7'd0, qacceptn}, {7'd0, vecs[i].e_qacceptn});
      chk($sformatf("vec%0d qdeny", i), {7'd0, qdeny}, {7'd0, vecs[i].e_qdeny});
      chk($sformatf("vec%0d req_vld_o", i), {5'd0, req_out}, {5'd0, vecs[i].e_req});
      chk($sformatf("vec%0d done_o", i), {7'd0, done_out}, {7'd0, vecs[i].e_done});
      chk($sformatf("vec%0d qactive", i), {7'd0, qactive}, {7'd0, vecs[i].e_qactive});
    end

    // Idle and timeout in the same cycle: DRAIN wins. Then busy aborts the drain.
    qreqn = 1'b0; busy = 1'b1; req_in = 3'b000; done_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("tie run%0d", i), {6'd0, state}, 8'd1);
    end
    busy = 1'b0;
    step();
    chk("tie drain wins", {6'd0, state}, 8'd2);
    busy = 1'b1;
    step();
    chk("tie abort deny", {6'd0, state}, 8'd3);
    qreqn = 1'b1; busy = 1'b0;
    step();
    chk("tie back to run", {6'd0, state}, 8'd1);

    // Busy timeout: qdeny rises on the 16th edge with qreqn low.
    qreqn = 1'b0; busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("timeout qdeny%0d", i), {7'd0, qdeny}, 8'd0);
    end
    step();
    chk("timeout state", {6'd0, state}, 8'd3);
    chk("timeout qdeny", {7'd0, qdeny}, 8'd1);
    chk("timeout qacceptn", {7'd0, qacceptn}, 8'd1);
    // DENY passes requests and never retries quiescence while qreqn stays low.
    busy = 1'b0; req_in = 3'b011;
    step();
    chk("deny req pass", {5'd0, req_out}, 8'h03);
    req_in = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("deny hold%0d", i), {6'd0, state}, 8'd3);
    end
    qreqn = 1'b1;
    step();
    chk("deny release qdeny", {7'd0, qdeny}, 8'd0);
    chk("deny release state", {6'd0, state}, 8'd1);

    // Drain abort at counter 3 by a request pulse; done passes during the drain.
    qreqn = 1'b0;
    step();
    chk("abort drain entry", {6'd0, state}, 8'd2);
    step();
    done_in = 1'b1;
    step();
    chk("abort done in drain", {7'd0, done_out}, 8'd1);
    done_in = 1'b0;
    step();
    chk("abort drain cnt3", {6'd0, state}, 8'd2);
    req_in = 3'b001;
    step();
    chk("abort state", {6'd0, state}, 8'd3);
    chk("abort qdeny", {7'd0, qdeny}, 8'd1);
    chk("abort qacceptn", {7'd0, qacceptn}, 8'd1);
    req_in = 3'b000; qreqn = 1'b1;
    step();
    chk("abort back to run", {6'd0, state}, 8'd1);

    // Reset at drain counter 5 returns straight to STOP.
    qreqn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rstdrain cnt%0d", i), {6'd0, state}, 8'd2);
    end
    rst = 1'b1; busy = 1'b1;
    step();
    chk("rstdrain state", {6'd0, state}, 8'd0);
    chk("rstdrain qacceptn", {7'd0, qacceptn}, 8'd0);
    chk("rstdrain qdeny", {7'd0, qdeny}, 8'd0);
    chk("rstdrain qactive", {7'd0, qactive}, 8'd0);
    rst = 1'b0; busy = 1'b0;

    // Timeout disabled: a busy unit holds RUN indefinitely, then drains once idle.
    qreqn2 = 1'b1;
    step();
    chk("nt run", {6'd0, state2}, 8'd1);
    qreqn2 = 1'b0; busy2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("nt hold state%0d", i), {6'd0, state2}, 8'd1);
      chk($sformatf("nt hold qdeny%0d", i), {7'd0, qdeny2}, 8'd0);
    end
    busy2 = 1'b0;
    step();
    chk("nt drain", {6'd0, state2}, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
